// File: rtl/noc_params.sv
// Shared NoC types and sizing: flit format, output ports, VC counts and the
// per-VC control state encoding used by the input VC bank.
package noc_params;

   localparam int unsigned VC_NUM    = 4;
   localparam int unsigned VC_DEPTH  = 4;
   // Wide enough for the largest supported bank (8 VCs), so an index past
   // N_VC is expressible on smaller banks and can be flagged.
   localparam int unsigned VC_SIZE   = 3;
   localparam int unsigned PAYLOAD_W = 16;

   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

   typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

   typedef struct packed {
      flit_label_t            flit_label;
      logic [PAYLOAD_W-1:0]   data;
   } flit_t;

   typedef enum logic [1:0] {IDLE, RC, VA, SA} vc_state_t;

   function automatic logic is_head(input flit_label_t l);
      return (l == HEAD) || (l == HEADTAIL);
   endfunction

   function automatic logic is_tail(input flit_label_t l);
      return (l == TAIL) || (l == HEADTAIL);
   endfunction

endpackage

// File: rtl/input_vc_bank_if.sv
// Upstream/switch-side signal bundle of the input VC bank.
// master: the side driving flits, grants and reads; slave: the bank itself.
interface input_vc_bank_if
   import noc_params::*;
#(
   parameter int unsigned N_VC = VC_NUM
);

   flit_t                           data_i;
   logic                            write_i;
   logic [VC_SIZE-1:0]              write_vc_i;
   port_t                           out_port_i;
   logic                            read_i;
   logic [VC_SIZE-1:0]              read_vc_i;
   logic [N_VC-1:0]                 vc_valid_i;
   logic [N_VC-1:0][VC_SIZE-1:0]    vc_new_i;

   flit_t                           data_o;
   logic [N_VC-1:0]                 is_full_o;
   logic [N_VC-1:0]                 is_empty_o;
   port_t [N_VC-1:0]                out_port_o;
   logic [N_VC-1:0][VC_SIZE-1:0]    downstream_vc_o;
   logic [N_VC-1:0]                 vc_request_o;
   logic [N_VC-1:0]                 switch_request_o;
   logic [N_VC-1:0]                 vc_allocatable_o;
   logic [N_VC-1:0]                 error_o;
   logic                            credit_o;
   logic [VC_SIZE-1:0]              credit_vc_o;

   modport master (
      output data_i, write_i, write_vc_i, out_port_i, read_i, read_vc_i,
             vc_valid_i, vc_new_i,
      input  data_o, is_full_o, is_empty_o, out_port_o, downstream_vc_o,
             vc_request_o, switch_request_o, vc_allocatable_o, error_o,
             credit_o, credit_vc_o
   );

   modport slave (
      input  data_i, write_i, write_vc_i, out_port_i, read_i, read_vc_i,
             vc_valid_i, vc_new_i,
      output data_o, is_full_o, is_empty_o, out_port_o, downstream_vc_o,
             vc_request_o, switch_request_o, vc_allocatable_o, error_o,
             credit_o, credit_vc_o
   );

endinterface

// File: rtl/circular_buffer.sv
// First-word-fall-through flit FIFO for one VC; head is valid while non-empty.
module circular_buffer
   import noc_params::*;
#(
   parameter int unsigned BUFFER_SIZE = VC_DEPTH
) (
   input  logic  clk,
   input  logic  rst,
   input  flit_t data,
   input  logic  push,
   input  logic  pop,
   output flit_t head,
   output logic  is_full,
   output logic  is_empty
);

   localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);

   flit_t            mem [BUFFER_SIZE];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   // flit storage, written at the tail slot
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= data;
   end

   // read/write pointers; the extra MSB separates full from empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   assign head     = mem[rd_ptr[PTR_W-1:0]];
   assign is_empty = (wr_ptr == rd_ptr);
   assign is_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/vc_ctrl_fsm.sv
// Per-VC packet control: route computation, VC allocation and switch
// allocation stages, plus protocol error detection for that VC.
module vc_ctrl_fsm
   import noc_params::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               write_cmd,
   input  flit_label_t        write_label,
   input  port_t              route,
   input  logic               read_cmd,
   input  flit_label_t        head_label,
   input  logic               is_empty,
   input  logic               vc_valid,
   input  logic [VC_SIZE-1:0] vc_new,
   output port_t              out_port,
   output logic [VC_SIZE-1:0] downstream_vc,
   output logic               vc_request,
   output logic               switch_request,
   output logic               vc_allocatable,
   output logic               error,
   output logic               drop
);

   vc_state_t state;
   vc_state_t state_nxt;
   port_t     route_q;
   logic      tail_in;
   logic      err_nxt;
   logic      alloc_nxt;
   logic      bad_write;

   assign vc_request     = (state == VA);
   assign switch_request = (state == SA) && !is_empty;
   // A BODY/TAIL flit at the head in RC cannot start a packet; it is
   // discarded so the VC does not spin through RC on the same flit.
   assign drop           = (state == RC) && !is_empty && !is_head(head_label);
   assign bad_write      = write_cmd && (is_head(write_label) || tail_in);

   // next state and protocol error detection
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      alloc_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (!is_empty) state_nxt = RC;
            if (vc_valid || read_cmd) err_nxt = 1'b1;
         end
         RC: begin
            if (vc_valid || read_cmd) err_nxt = 1'b1;
            if (is_empty) begin
               state_nxt = IDLE;
            end else if (is_head(head_label)) begin
               state_nxt = VA;
            end else begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         VA: begin
            if (read_cmd || bad_write) err_nxt = 1'b1;
            if (vc_valid) state_nxt = SA;
         end
         SA: begin
            if (vc_valid || bad_write) err_nxt = 1'b1;
            if (read_cmd && is_tail(head_label)) begin
               state_nxt = IDLE;
               alloc_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state, latched route, allocated VC and one-cycle status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         route_q        <= LOCAL;
         out_port       <= LOCAL;
         downstream_vc  <= '0;
         tail_in        <= 1'b0;
         error          <= 1'b0;
         vc_allocatable <= 1'b0;
      end else begin
         state          <= state_nxt;
         error          <= err_nxt;
         vc_allocatable <= alloc_nxt;
         if (write_cmd && is_head(write_label) && (state == IDLE || state == RC))
            route_q <= route;
         if (state == RC && state_nxt == VA)
            out_port <= route_q;
         if (state == VA && vc_valid)
            downstream_vc <= vc_new;
         if (write_cmd && is_tail(write_label))
            tail_in <= 1'b1;
         else if ((read_cmd || drop) && is_tail(head_label))
            tail_in <= 1'b0;
      end
   end

endmodule

// File: rtl/input_vc_bank.sv
// Input VC bank: one FIFO and one control FSM per virtual channel, a shared
// write port, a shared FWFT read port and credit return to upstream.
// Optional feature: define IVB_ERR_CNT_EN to add err_count_o, a saturating
// count of cycles with any error_o bit set.
module input_vc_bank
   import noc_params::*;
#(
   parameter int unsigned N_VC        = VC_NUM,
   parameter int unsigned BUFFER_SIZE = VC_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input_vc_bank_if.slave     bus
`ifdef IVB_ERR_CNT_EN
   ,
   output logic [7:0]         err_count_o
`endif
);

   logic [N_VC-1:0] write_sel;
   logic [N_VC-1:0] read_sel;
   logic [N_VC-1:0] push;
   logic [N_VC-1:0] pop;
   logic [N_VC-1:0] drop;
   logic [N_VC-1:0] full;
   logic [N_VC-1:0] empty;
   logic [N_VC-1:0] fsm_err;
   flit_t           head [N_VC];
   logic            write_cmd;
   logic            read_cmd;
   logic            range_err;
   logic            range_err_q;

   // one-hot decode of write/read VC; all-zero means out of range
   always_comb begin
      write_sel = '0;
      read_sel  = '0;
      for (int unsigned k = 0; k < N_VC; k++) begin
         write_sel[k] = (bus.write_vc_i == k[VC_SIZE-1:0]);
         read_sel[k]  = (bus.read_vc_i == k[VC_SIZE-1:0]);
      end
   end

   // fullness is sampled before this cycle's read, so a full VC drops the write
   assign write_cmd = bus.write_i && |(write_sel & ~full);
   assign read_cmd  = bus.read_i && |(read_sel & ~empty);
   assign range_err = (bus.write_i && (write_sel == '0)) ||
                      (bus.read_i && (read_sel == '0));
   assign push      = write_sel & {N_VC{write_cmd}};
   assign pop       = (read_sel & {N_VC{read_cmd}}) | drop;

   // FWFT read mux
   always_comb begin
      bus.data_o = '0;
      for (int unsigned k = 0; k < N_VC; k++) begin
         if (read_sel[k]) bus.data_o = head[k];
      end
   end

   // credit return and registered out-of-range error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.credit_o    <= 1'b0;
         bus.credit_vc_o <= '0;
         range_err_q     <= 1'b0;
      end else begin
         bus.credit_o    <= read_cmd;
         bus.credit_vc_o <= read_cmd ? bus.read_vc_i : '0;
         range_err_q     <= range_err;
      end
   end

   assign bus.is_full_o  = full;
   assign bus.is_empty_o = empty;
   assign bus.error_o    = fsm_err | {{(N_VC-1){1'b0}}, range_err_q};

   for (genvar k = 0; k < N_VC; k++) begin : g_vc
      circular_buffer #(
         .BUFFER_SIZE (BUFFER_SIZE)
      ) u_buf (
         .clk      (clk),
         .rst      (rst),
         .data     (bus.data_i),
         .push     (push[k]),
         .pop      (pop[k]),
         .head     (head[k]),
         .is_full  (full[k]),
         .is_empty (empty[k])
      );

      vc_ctrl_fsm u_fsm (
         .clk            (clk),
         .rst            (rst),
         .write_cmd      (push[k]),
         .write_label    (bus.data_i.flit_label),
         .route          (bus.out_port_i),
         .read_cmd       (read_sel[k] & read_cmd),
         .head_label     (head[k].flit_label),
         .is_empty       (empty[k]),
         .vc_valid       (bus.vc_valid_i[k]),
         .vc_new         (bus.vc_new_i[k]),
         .out_port       (bus.out_port_o[k]),
         .downstream_vc  (bus.downstream_vc_o[k]),
         .vc_request     (bus.vc_request_o[k]),
         .switch_request (bus.switch_request_o[k]),
         .vc_allocatable (bus.vc_allocatable_o[k]),
         .error          (fsm_err[k]),
         .drop           (drop[k])
      );
   end

`ifdef IVB_ERR_CNT_EN
   // saturating count of cycles with any error flag raised
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_count_o <= '0;
      else if (|bus.error_o && (err_count_o != 8'hFF))
         err_count_o <= err_count_o + 8'd1;
   end
`endif

endmodule

// File: tb/tb_input_vc_bank.sv
// Directed bench for input_vc_bank (4 VCs, depth 4) with hand-computed
// expectations; the err_count_o section is built only with IVB_ERR_CNT_EN.
module tb_input_vc_bank;
   import noc_params::*;

   localparam int unsigned NV    = 4;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   int unsigned t2_vc  [6] = '{0, 2, 0, 2, 0, 2};
   flit_label_t t2_lbl [6] = '{HEAD, HEAD, BODY, BODY, TAIL, TAIL};
   logic [15:0] t2_dat [6] = '{16'h10, 16'h20, 16'h11, 16'h21, 16'h12, 16'h22};
   logic [3:0]  t2_alc [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100};

   input_vc_bank_if #(.N_VC(NV)) bus ();

`ifdef IVB_ERR_CNT_EN
   logic [7:0] err_count;
`endif

   input_vc_bank #(
      .N_VC        (NV),
      .BUFFER_SIZE (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef IVB_ERR_CNT_EN
      , .err_count_o (err_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic flit_t mk(input flit_label_t l, input logic [15:0] d);
      flit_t f;
      f.flit_label = l;
      f.data       = d;
      return f;
   endfunction

   task automatic write_flit(input logic [VC_SIZE-1:0] vc, input flit_label_t l,
                             input logic [15:0] d, input port_t p);
      bus.write_i    = 1'b1;
      bus.write_vc_i = vc;
      bus.data_i     = mk(l, d);
      bus.out_port_i = p;
      step();
      bus.write_i    = 1'b0;
   endtask

   task automatic read_flit(input logic [VC_SIZE-1:0] vc, input flit_label_t l,
                            input logic [15:0] d, input string tag);
      bus.read_i    = 1'b1;
      bus.read_vc_i = vc;
      #1;
      check({tag, "_data"}, 32'(bus.data_o), 32'(mk(l, d)));
      step();
      bus.read_i = 1'b0;
      check({tag, "_credit"}, 32'(bus.credit_o), 32'd1);
      check({tag, "_credit_vc"}, 32'(bus.credit_vc_o), 32'(vc));
   endtask

   initial begin
      rst            = 1'b1;
      bus.data_i     = '0;
      bus.write_i    = 1'b0;
      bus.write_vc_i = '0;
      bus.out_port_i = LOCAL;
      bus.read_i     = 1'b0;
      bus.read_vc_i  = '0;
      bus.vc_valid_i = '0;
      bus.vc_new_i   = '0;
      repeat (2) @(posedge clk);
      #2;

      // reset values
      check("rst_empty", 32'(bus.is_empty_o), 32'hF);
      check("rst_full", 32'(bus.is_full_o), 32'h0);
      check("rst_error", 32'(bus.error_o), 32'h0);
      check("rst_credit", 32'(bus.credit_o), 32'h0);
      check("rst_vcreq", 32'(bus.vc_request_o), 32'h0);
      check("rst_swreq", 32'(bus.switch_request_o), 32'h0);
      check("rst_alloc", 32'(bus.vc_allocatable_o), 32'h0);
      check("rst_outport1", 32'(bus.out_port_o[1]), 32'(LOCAL));
      check("rst_dsvc", 32'(bus.downstream_vc_o), 32'h0);
      rst = 1'b0;
      step();

      // single HEADTAIL packet through VC1
      write_flit(3'd1, HEADTAIL, 16'hA1, EAST);
      check("t1_empty", 32'(bus.is_empty_o), 32'b1101);
      step();
      check("t1_vcreq_rc", 32'(bus.vc_request_o), 32'h0);
      step();
      check("t1_vcreq_va", 32'(bus.vc_request_o), 32'b0010);
      check("t1_outport", 32'(bus.out_port_o[1]), 32'(EAST));
      bus.vc_valid_i  = 4'b0010;
      bus.vc_new_i[1] = 3'd2;
      step();
      bus.vc_valid_i  = '0;
      check("t1_swreq", 32'(bus.switch_request_o), 32'b0010);
      check("t1_dsvc", 32'(bus.downstream_vc_o[1]), 32'd2);
      check("t1_vcreq_sa", 32'(bus.vc_request_o), 32'h0);
      read_flit(3'd1, HEADTAIL, 16'hA1, "t1_rd");
      check("t1_alloc", 32'(bus.vc_allocatable_o), 32'b0010);
      check("t1_empty_after", 32'(bus.is_empty_o), 32'hF);
      check("t1_error", 32'(bus.error_o), 32'h0);
      step();
      check("t1_alloc_pulse", 32'(bus.vc_allocatable_o), 32'h0);
      check("t1_credit_pulse", 32'(bus.credit_o), 32'h0);
      check("t1_outport_hold", 32'(bus.out_port_o[1]), 32'(EAST));

      // interleaved 3-flit packets on VC0 and VC2
      write_flit(3'd0, HEAD, 16'h10, NORTH);
      write_flit(3'd2, HEAD, 16'h20, WEST);
      write_flit(3'd0, BODY, 16'h11, LOCAL);
      write_flit(3'd2, BODY, 16'h21, LOCAL);
      write_flit(3'd0, TAIL, 16'h12, LOCAL);
      write_flit(3'd2, TAIL, 16'h22, LOCAL);
      check("t2_error", 32'(bus.error_o), 32'h0);
      check("t2_vcreq", 32'(bus.vc_request_o), 32'b0101);
      check("t2_outport0", 32'(bus.out_port_o[0]), 32'(NORTH));
      check("t2_outport2", 32'(bus.out_port_o[2]), 32'(WEST));
      bus.vc_valid_i  = 4'b0101;
      bus.vc_new_i[0] = 3'd3;
      bus.vc_new_i[2] = 3'd1;
      step();
      bus.vc_valid_i  = '0;
      check("t2_dsvc", 32'(bus.downstream_vc_o), 32'h53);
      check("t2_swreq", 32'(bus.switch_request_o), 32'b0101);
      for (int i = 0; i < 6; i++) begin
         read_flit(t2_vc[i][VC_SIZE-1:0], t2_lbl[i], t2_dat[i], $sformatf("t2_rd%0d", i));
         check($sformatf("t2_alloc%0d", i), 32'(bus.vc_allocatable_o), 32'(t2_alc[i]));
      end
      check("t2_empty_after", 32'(bus.is_empty_o), 32'hF);
      check("t2_error_after", 32'(bus.error_o), 32'h0);

      // fill VC0, then simultaneous write+read while full
      write_flit(3'd0, HEAD, 16'h30, SOUTH);
      write_flit(3'd0, BODY, 16'h31, LOCAL);
      write_flit(3'd0, BODY, 16'h32, LOCAL);
      write_flit(3'd0, TAIL, 16'h33, LOCAL);
      check("t3_full", 32'(bus.is_full_o), 32'b0001);
      check("t3_vcreq", 32'(bus.vc_request_o), 32'b0001);
      bus.vc_valid_i  = 4'b0001;
      bus.vc_new_i[0] = 3'd1;
      step();
      bus.vc_valid_i  = '0;
      bus.write_i     = 1'b1;
      bus.write_vc_i  = 3'd0;
      bus.data_i      = mk(BODY, 16'h99);
      bus.read_i      = 1'b1;
      bus.read_vc_i   = 3'd0;
      #1;
      check("t3_head", 32'(bus.data_o), 32'(mk(HEAD, 16'h30)));
      step();
      bus.write_i = 1'b0;
      bus.read_i  = 1'b0;
      check("t3_full_after", 32'(bus.is_full_o), 32'h0);
      check("t3_credit", 32'(bus.credit_o), 32'd1);
      check("t3_credit_vc", 32'(bus.credit_vc_o), 32'd0);
      check("t3_error", 32'(bus.error_o), 32'h0);
      read_flit(3'd0, BODY, 16'h31, "t3_rd1");
      read_flit(3'd0, BODY, 16'h32, "t3_rd2");
      read_flit(3'd0, TAIL, 16'h33, "t3_rd3");
      check("t3_alloc", 32'(bus.vc_allocatable_o), 32'b0001);
      check("t3_empty", 32'(bus.is_empty_o), 32'hF);

      // BODY flit into empty VC3
      write_flit(3'd3, BODY, 16'h40, LOCAL);
      check("t4_empty", 32'(bus.is_empty_o), 32'b0111);
      step();
      check("t4_error_rc", 32'(bus.error_o), 32'h0);
      step();
      check("t4_error", 32'(bus.error_o), 32'b1000);
      check("t4_empty_after", 32'(bus.is_empty_o), 32'hF);
      check("t4_credit", 32'(bus.credit_o), 32'h0);
      step();
      check("t4_error_pulse", 32'(bus.error_o), 32'h0);
      check("t4_vcreq", 32'(bus.vc_request_o), 32'h0);

      // out-of-range write and read indices
      bus.write_i    = 1'b1;
      bus.write_vc_i = 3'd5;
      bus.data_i     = mk(HEAD, 16'h55);
      step();
      bus.write_i    = 1'b0;
      check("t5_wr_error", 32'(bus.error_o), 32'b0001);
      check("t5_wr_empty", 32'(bus.is_empty_o), 32'hF);
      step();
      check("t5_error_clear", 32'(bus.error_o), 32'h0);
      bus.read_i    = 1'b1;
      bus.read_vc_i = 3'd6;
      step();
      bus.read_i    = 1'b0;
      check("t5_rd_error", 32'(bus.error_o), 32'b0001);
      check("t5_rd_credit", 32'(bus.credit_o), 32'h0);

      // VC grant while idle
      bus.vc_valid_i = 4'b0100;
      step();
      bus.vc_valid_i = '0;
      check("t6_error", 32'(bus.error_o), 32'b0100);
      check("t6_vcreq", 32'(bus.vc_request_o), 32'h0);
      step();
      check("t6_error_clear", 32'(bus.error_o), 32'h0);

      // reset mid-packet with two flits queued
      write_flit(3'd1, HEAD, 16'h50, NORTH);
      write_flit(3'd1, BODY, 16'h51, LOCAL);
      step();
      check("t7_outport", 32'(bus.out_port_o[1]), 32'(NORTH));
      check("t7_vcreq", 32'(bus.vc_request_o), 32'b0010);
      check("t7_empty", 32'(bus.is_empty_o), 32'b1101);
      bus.read_i    = 1'b1;
      bus.read_vc_i = 3'd1;
      rst           = 1'b1;
      #1;
      check("t7_rst_empty", 32'(bus.is_empty_o), 32'hF);
      check("t7_rst_outport", 32'(bus.out_port_o[1]), 32'(LOCAL));
      check("t7_rst_vcreq", 32'(bus.vc_request_o), 32'h0);
      check("t7_rst_dsvc", 32'(bus.downstream_vc_o), 32'h0);
      step();
      check("t7_rst_credit", 32'(bus.credit_o), 32'h0);
      bus.read_i = 1'b0;
      rst        = 1'b0;
      step();
      check("t7_credit_after", 32'(bus.credit_o), 32'h0);
      check("t7_empty_after", 32'(bus.is_empty_o), 32'hF);
      check("t7_error_after", 32'(bus.error_o), 32'h0);

`ifdef IVB_ERR_CNT_EN
      // saturating error-cycle counter
      check("t8_cnt_start", 32'(err_count), 32'd0);
      bus.vc_valid_i = 4'b0001;
      repeat (10) step();
      check("t8_cnt_9", 32'(err_count), 32'd9);
      repeat (300) step();
      check("t8_cnt_sat", 32'(err_count), 32'd255);
      bus.vc_valid_i = '0;
      repeat (2) step();
      check("t8_cnt_hold", 32'(err_count), 32'd255);
      check("t8_error_clear", 32'(bus.error_o), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/input_vc_bank.md
INPUT_VC_BANK -- requirements
Module: input_vc_bank

Interface
REQ-001 Parameter N_VC, default VC_NUM: number of virtual channels; 2 to 8 supported.
REQ-002 Parameter BUFFER_SIZE, default VC_DEPTH: flits per VC; a power of two, 2 or more.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 data_i  in  flit_t  incoming flit.
REQ-006 write_i  in  1  write intent.
REQ-007 write_vc_i  in  VC_SIZE  target VC of the write.
REQ-008 out_port_i  in  port_t  route for a HEAD/HEADTAIL write.
REQ-009 read_i  in  1  read intent (switch grant).
REQ-010 read_vc_i  in  VC_SIZE  VC to read.
REQ-011 vc_valid_i  in  N_VC  per-VC downstream-VC grant.
REQ-012 vc_new_i  in  N_VC x VC_SIZE  granted downstream VC, per VC.
REQ-013 data_o  out  flit_t  head flit of read_vc_i (FWFT).
REQ-014 is_full_o, is_empty_o  out  N_VC each  per-VC occupancy flags.
REQ-015 out_port_o  out  N_VC x port_t  per-VC finalised route.
REQ-016 downstream_vc_o  out  N_VC x VC_SIZE  per-VC allocated downstream VC.
REQ-017 vc_request_o, switch_request_o, vc_allocatable_o, error_o  out  N_VC each  per-VC control flags.
REQ-018 credit_o  out  1, credit_vc_o  out  VC_SIZE  credit return to upstream.

Function
REQ-019 write_cmd SHALL be write_i AND NOT is_full_o[write_vc_i]; read_cmd SHALL be read_i AND NOT is_empty_o[read_vc_i]; write_vc_i or read_vc_i of N_VC or above SHALL suppress the command and pulse error_o[0].
REQ-020 Each VC SHALL run an independent FSM IDLE->RC->VA->SA->IDLE, driven only by its own write_cmd/read_cmd/empty/vc_valid_i.
REQ-021 IDLE->RC when the VC is non-empty; RC->VA when its head is HEAD/HEADTAIL, with out_port_o loaded from the route latched on that head's write.
REQ-022 VA: vc_request_o=1; vc_valid_i loads downstream_vc_o from vc_new_i and moves to SA.
REQ-023 SA: switch_request_o=1 while non-empty; read_cmd of a TAIL/HEADTAIL head SHALL return the VC to IDLE and pulse vc_allocatable_o for exactly one cycle.
REQ-024 Protocol errors SHALL set error_o of that VC for one cycle: BODY/TAIL head in RC (->IDLE); vc_valid_i in IDLE/RC/SA; read_cmd in IDLE/RC/VA; HEAD/HEADTAIL write, or any write after the tail, in VA/SA.
REQ-025 A read and a write in one cycle, to the same or different VCs, SHALL both complete; fullness SHALL be evaluated before the read.
REQ-026 credit_o SHALL pulse one cycle after each read_cmd, with credit_vc_o equal to the read VC; there SHALL be no credit without a read.
REQ-027 data_o SHALL be combinational from read_vc_i with zero latency; it is undefined when that VC is empty.

Reset
REQ-028 While rst=1: all FSMs IDLE; FIFOs empty; out_port_o=LOCAL; downstream_vc_o=0; all request/allocatable/error/credit outputs 0; is_empty_o all 1.
REQ-029 Reset asserted mid-packet SHALL discard all buffered flits, with no credits returned.

Configuration
REQ-030 With IVB_ERR_CNT_EN defined: an extra output err_count_o (8 bits) SHALL count cycles with any error_o bit set, saturating at 255, cleared by rst.
REQ-031 Without IVB_ERR_CNT_EN: the port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-032 flit_t, port_t, VC_NUM, VC_SIZE and VC_DEPTH SHALL come from noc_params; the FSM state enum SHALL be added there.
REQ-033 Storage SHALL be one circular_buffer per VC (generate loop); per-VC control SHALL be one sub-module, vc_ctrl_fsm.

Verification
REQ-034 HEADTAIL write to VC1 (out_port_i=EAST), vc_valid_i[1]=1 with vc_new_i=2, then read VC1 -> out_port_o[1]=EAST, downstream_vc_o[1]=2, vc_allocatable_o[1] pulses, credit_vc_o=1.
REQ-035 Interleaved 3-flit packets on VC0 and VC2 -> each drains in order, with no cross-VC corruption.
REQ-036 Fill VC0 to BUFFER_SIZE, then simultaneous write+read on VC0 -> write dropped, count drops to BUFFER_SIZE-1, one credit returned.
REQ-037 BODY flit first into an empty VC3 -> error_o[3]=1 for one cycle, FSM back to IDLE.
REQ-038 rst pulse with 2 flits queued -> all outputs at reset values, no credit_o.
REQ-039 IVB_ERR_CNT_EN with 300 error cycles -> err_count_o=255.
